// File: rtl/mem_arb_pkg.sv
// Shared definitions for the image/data RAM arbiter: master IDs, default widths
// and the read-return pipeline entry.
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 8;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_entry_t;

endpackage

// File: rtl/rd_return_pipe.sv
// Tracks outstanding reads for RD_LAT+1 cycles so returning RAM data can be
// steered to the master that issued the read.
module rd_return_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rd_entry_t push_i,
  output logic      m0_rvalid_o,
  output logic      m1_rvalid_o
);

  localparam int unsigned DEPTH = RD_LAT + 1;

  rd_entry_t [DEPTH-1:0] pipe_q;
  rd_entry_t [DEPTH-1:0] pipe_d;
  rd_entry_t             tail;

  always_comb begin
    pipe_d = {pipe_q[DEPTH-2:0], push_i};
  end

  // Clearing on reset drops every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tail        = pipe_q[DEPTH-1];
  assign m0_rvalid_o = tail.valid && (tail.owner == M_CPU);
  assign m1_rvalid_o = tail.valid && (tail.owner == M_LDR);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port image RAM between the CPU path
// (master 0) and the image loader (master 1), with a bounded loader burst lock.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,

  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_lock_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,

  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  // Priority pointer states: which master wins when both request.
  localparam logic [0:0] PTR_CPU = 1'b0;
  localparam logic [0:0] PTR_LDR = 1'b1;

  logic [0:0]       ptr_q,       ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             ram_en_q,    ram_en_d;
  logic             ram_we_q,    ram_we_d;
  logic [AW-1:0]    ram_addr_q,  ram_addr_d;
  logic [DW-1:0]    ram_wdata_q, ram_wdata_d;

  logic      gnt0;
  logic      gnt1;
  rd_entry_t push;

  // Grant selection, pointer/burst bookkeeping and command-stage next state.
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    push        = '0;

    if (rst_n) begin
      if (m0_req_i && (!m1_req_i || (ptr_q == PTR_CPU))) begin
        gnt0 = 1'b1;
      end else if (m1_req_i) begin
        gnt1 = 1'b1;
      end
    end

    if (gnt0) begin
      ptr_d       = PTR_LDR;
      burst_cnt_d = '0;
      ram_en_d    = 1'b1;
      ram_we_d    = m0_we_i;
      ram_addr_d  = m0_addr_i;
      ram_wdata_d = m0_wdata_i;
      push.valid  = !m0_we_i;
      push.owner  = M_CPU;
    end else if (gnt1) begin
      // A locked burst only consumes budget while the CPU is actually waiting.
      if (m1_lock_i && (burst_cnt_q < BURST_LAST)) begin
        ptr_d = PTR_LDR;
        if (m0_req_i) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end else begin
        ptr_d       = PTR_CPU;
        burst_cnt_d = '0;
      end
      ram_en_d    = 1'b1;
      ram_we_d    = m1_we_i;
      ram_addr_d  = m1_addr_i;
      ram_wdata_d = m1_wdata_i;
      push.valid  = !m1_we_i;
      push.owner  = M_LDR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PTR_CPU;
      burst_cnt_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  rd_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_return_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .m0_rvalid_o (m0_rvalid_o),
    .m1_rvalid_o (m1_rvalid_o)
  );

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rdata_o  = ram_rdata_i;
  assign m1_rdata_o  = ram_rdata_i;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected read returns into a
// queue, a monitor pops and compares whenever an rvalid appears.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] rd_q;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(1), .MAX_BURST(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_lock_i   (m1_lock),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  // Single-port RAM model, one cycle read latency; contents reloaded during reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[16'h0010] <= 8'hA5;
      mem[16'h0200] <= 8'h55;
      mem[16'h0201] <= 8'h56;
      for (int k = 0; k < 8; k++) begin
        mem[16'h0020 + 16'(k)] <= 8'h10 + 8'(k);
        mem[16'h0040 + 16'(k)] <= 8'h80 + 8'(k);
      end
      for (int k = 0; k < 9; k++) mem[16'h0300 + 16'(k)] <= 8'hC0 + 8'(k);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        rd_q <= mem[ram_addr];
    end
  end
  assign ram_rdata = rd_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic expect_rd(input logic owner, input logic [DW-1:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  // Monitor: every rvalid must match the oldest outstanding expected read.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (m0_rvalid || m1_rvalid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_owner", 32'({m1_rvalid, m0_rvalid}), e.owner ? 32'd2 : 32'd1);
        check("rdata", 32'(e.owner ? m1_rdata : m0_rdata), 32'(e.data));
      end
    end
  end

  initial begin
    int  k0;
    int  k1;
    logic exp_m1;

    // Reset: grants forced low even with both masters requesting.
    rst_n = 1'b0;
    idle();
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    check("rst_gnt0", 32'(m0_gnt), 32'd0);
    check("rst_gnt1", 32'(m1_gnt), 32'd0);
    repeat (3) next_cyc();
    mid();
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    next_cyc();
    rst_n = 1'b1;
    idle();

    // Single read by master 0.
    next_cyc();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
    mid();
    check("rd_gnt0", 32'(m0_gnt), 32'd1);
    check("rd_gnt1", 32'(m1_gnt), 32'd0);
    expect_rd(1'b0, 8'hA5);
    next_cyc();
    idle();
    mid();
    check("rd_ram_en", 32'(ram_en), 32'd1);
    check("rd_ram_we", 32'(ram_we), 32'd0);
    check("rd_ram_addr", 32'(ram_addr), 32'h0010);
    repeat (3) next_cyc();

    // Both masters read continuously: strict alternation from master 0.
    do_reset();
    k0 = 0; k1 = 0;
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0020 + 16'(k0);
      m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 16'h0040 + 16'(k1);
      mid();
      exp_m1 = (i % 2) != 0;
      check("alt_gnt0", 32'(m0_gnt), 32'(!exp_m1));
      check("alt_gnt1", 32'(m1_gnt), 32'(exp_m1));
      if (exp_m1) begin
        expect_rd(1'b1, 8'h80 + 8'(k1));
        k1++;
      end else begin
        expect_rd(1'b0, 8'h10 + 8'(k0));
        k0++;
      end
      if (i > 0) check("alt_ram_en", 32'(ram_en), 32'd1);
    end
    next_cyc();
    idle();
    mid();
    check("alt_ram_en_last", 32'(ram_en), 32'd1);
    next_cyc();
    mid();
    check("alt_ram_en_off", 32'(ram_en), 32'd0);

    // Loader write then CPU read of the same address: new data returned.
    next_cyc();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0100; m1_wdata = 8'h3C;
    mid();
    check("wr_gnt1", 32'(m1_gnt), 32'd1);
    next_cyc();
    idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0100;
    mid();
    check("wr_rd_gnt0", 32'(m0_gnt), 32'd1);
    check("wr_ram_en", 32'(ram_en), 32'd1);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'h0100);
    check("wr_ram_wdata", 32'(ram_wdata), 32'h3C);
    expect_rd(1'b0, 8'h3C);
    next_cyc();
    idle();
    mid();
    check("wr_rd_ram_en", 32'(ram_en), 32'd1);
    check("wr_rd_ram_we", 32'(ram_we), 32'd0);
    check("wr_rd_ram_addr", 32'(ram_addr), 32'h0100);
    repeat (3) next_cyc();

    // Locked loader burst with CPU waiting: 8 loader grants, CPU, loader again.
    k1 = 0;
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = (i <= 8) ? 16'h0200 : 16'h0201;
      m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1; m1_addr = 16'h0300 + 16'(k1);
      mid();
      exp_m1 = (i != 8);
      check("burst_gnt0", 32'(m0_gnt), 32'(!exp_m1));
      check("burst_gnt1", 32'(m1_gnt), 32'(exp_m1));
      if (exp_m1) begin
        expect_rd(1'b1, 8'hC0 + 8'(k1));
        k1++;
      end else begin
        expect_rd(1'b0, 8'h55);
      end
    end
    next_cyc();
    idle();
    repeat (3) next_cyc();

    // Reset during an in-flight read: it must never return.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
    mid();
    check("mrst_gnt0", 32'(m0_gnt), 32'd1);
    next_cyc();
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 16'h0010;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0040;
    mid();
    check("mrst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    check("mrst_ram_en", 32'(ram_en), 32'd0);
    check("mrst_ram_we", 32'(ram_we), 32'd0);
    check("mrst_ram_addr", 32'(ram_addr), 32'd0);
    check("mrst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    next_cyc();
    rst_n = 1'b1;
    mid();
    check("mrst_post_gnt0", 32'(m0_gnt), 32'd1);
    check("mrst_post_gnt1", 32'(m1_gnt), 32'd0);
    check("mrst_no_rvalid_t2", 32'(m0_rvalid), 32'd0);
    expect_rd(1'b0, 8'hA5);
    next_cyc();
    m0_req = 1'b0;
    mid();
    check("mrst_m1_gnt", 32'(m1_gnt), 32'd1);
    check("mrst_no_rvalid_t3", 32'(m0_rvalid), 32'd0);
    expect_rd(1'b1, 8'h80);
    next_cyc();
    idle();
    repeat (3) next_cyc();

    // CPU withdraws while the loader holds the grant, then everyone idles.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0500; m0_wdata = 8'h11;
    mid();
    check("wd_gnt0_setup", 32'(m0_gnt), 32'd1);
    next_cyc();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 16'h0501; m1_wdata = 8'h22;
    mid();
    check("wd_gnt1", 32'(m1_gnt), 32'd1);
    check("wd_gnt0_wait", 32'(m0_gnt), 32'd0);
    next_cyc();
    idle();
    mid();
    check("wd_no_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    next_cyc();
    mid();
    check("wd_ram_en_off", 32'(ram_en), 32'd0);
    next_cyc();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0040;
    mid();
    check("wd_ptr_cpu", 32'(m0_gnt), 32'd1);
    expect_rd(1'b0, 8'hA5);
    next_cyc();
    idle();

    repeat (5) next_cyc();
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port image/data RAM between two requesters: master 0, the processor control unit's RAM path, and master 1, the image loader/DMA port that streams pixels in and out.
- Issues at most one access per cycle to the RAM through a registered command stage.
- Arbitration is round-robin with a bounded burst lock for the loader.
- Routes read data back to the originating master after a fixed RAM read latency.

Parameters:
- AW, 16, address width (256x256 pixel image space).
- DW, 8, data width (one pixel).
- RD_LAT, 1, RAM read latency in cycles from the RAM sampling ram_en to ram_rdata valid; legal range 1..4.
- MAX_BURST, 8, maximum consecutive locked grants to master 1 while master 0 is waiting; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request; held until m0_gnt.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  master 0 request accepted this cycle (combinational).
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DW  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- m1_lock  in  1  master 1 burst lock request; sampled together with m1_req.
- ram_en  out  1  RAM access strobe (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  AW  RAM address (registered).
- ram_wdata  out  DW  RAM write data (registered).
- ram_rdata  in  DW  RAM read data.

Behaviour:
- Reset (async, rst_n=0):
  - ram_en, ram_we, m0_rvalid, m1_rvalid = 0; ram_addr, ram_wdata = 0.
  - Priority pointer = master 0; burst_cnt = 0; read-return pipeline cleared.
  - m0_gnt and m1_gnt are forced 0 while rst_n=0.
- Arbitration, cycle t, combinational:
  - Only one requester: it is granted.
  - Both requesting: the pointer holder is granted.
  - At most one gnt per cycle. No request means no gnt and ram_en=0 at t+1.
- Pointer update on each grant:
  - Default: the pointer moves to the master not just granted.
  - Exception: master 1 granted with m1_lock=1 and burst_cnt < MAX_BURST-1 leaves the pointer at master 1 and increments burst_cnt.
  - burst_cnt clears on any master 0 grant, on any master 1 grant with m1_lock=0, and on a locked grant that reaches MAX_BURST. That last grant sets the pointer to master 0, so master 0 is served next if requesting.
  - Locked grants with m0_req=0 do not increment burst_cnt; the lock never starves master 0 beyond MAX_BURST cycles.
- Command stage: the winner's we/addr/wdata are registered at the edge ending cycle t. ram_en=1 and ram_we=we appear during t+1, for exactly one cycle per grant.
- Back-to-back grants are allowed every cycle (full throughput). Alternating masters incur no bubble.
- Read return:
  - A granted read pushes {valid=1, owner} into an RD_LAT+1 deep shift pipeline.
  - mX_rvalid=1 during cycle t+1+RD_LAT, for the owner only.
  - mX_rdata = ram_rdata, passed through. It is undefined when rvalid=0 and is not required to hold.
- Writes produce no rvalid. A write followed by a read to the same address in the next grant returns the new data; the RAM is write-first by command order.
- Master outputs: rvalid and rdata are registered/pipeline-qualified. gnt is the only combinational output.
- Mid-operation reset: in-flight reads are dropped and no rvalid is produced after rst_n deasserts. Requesters must re-issue.
- Request withdrawal before gnt is permitted. Changing addr/we/wdata while req=1 and gnt=0 is permitted; values are sampled only in the gnt cycle.

Decomposition:
- Package mem_arb_pkg: master ID constants (M_CPU=0, M_LDR=1), default AW/DW, and the return-pipeline entry type {valid, owner}.
- Sub-module rd_return_pipe: parameterised RD_LAT+1 shift register of {valid, owner} with async active-low clear. It outputs per-owner rvalid.
- The arbiter FSM, pointer, burst counter and command register stay in mem_arbiter.

Test Plan:
- After reset, m0 reads 0x0010, RAM holds 0xA5 there. Expected: m0_gnt at t; ram_en=1, ram_we=0, ram_addr=0x0010 at t+1; m0_rvalid=1 with m0_rdata=0xA5 at t+2 (RD_LAT=1); m1_rvalid stays 0.
- m0 and m1 both request reads continuously for 6 cycles, m1_lock=0. Expected: grants alternate m0, m1, m0, m1, m0, m1, starting with m0; 6 consecutive ram_en cycles; rvalid returns to the correct owner in the same order.
- m1 writes 0x3C to 0x0100, then m0 reads 0x0100 in the next cycle. Expected: ram_we=1 then ram_we=0 on consecutive cycles; m0_rdata=0x3C; no rvalid for the write.
- MAX_BURST=8, m1_lock=1, m1_req held, m0_req asserted throughout. Expected: m1 receives exactly 8 consecutive grants, m0 the 9th, then m1 resumes.
- m0 issues a read, and rst_n pulses low for 1 cycle at t+1. Expected: all outputs 0 during reset; no m0_rvalid at t+2 or later; next grant after reset goes to m0 if both request.
- m0 withdraws m0_req while m1 holds the grant, then m1 idles. Expected: no m0_gnt, ram_en=0, burst_cnt=0.
